// File: rtl/f5_sweep.sv
// f5_sweep: in-circuit truth-table sweeper for an N-input NOR gate.
// It drives each input row onto the gate, waits SETTLE cycles, then samples
// the gate output and compares it with the expected NOR value. It counts
// mismatches and keeps the first failing row.
module f5_sweep #(
    parameter int unsigned N      = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [N-1:0] ab,
    input  logic         s,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic [N-1:0] fail_row
);

    // The wait counter only needs to hold SETTLE, and it always has at least one bit.
    localparam int unsigned CntW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCheck,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    ab_q, ab_d;
    logic            busy_q, busy_d;
    logic            pass_q, pass_d;
    logic [N:0]      err_q, err_d;
    logic [N-1:0]    fail_q, fail_d;

    logic exp_s;
    logic mismatch;
    logic last_row;

    // Only the all-zero row gives a high output from NOR.
    assign exp_s    = (ab_q == '0);
    assign mismatch = (s != exp_s);
    assign last_row = &ab_q;

    // State and datapath registers. Reset is asynchronous and clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ab_q    <= '0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ab_q    <= ab_d;
            busy_q  <= busy_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    // Next-state logic for the sweep FSM and its datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ab_d    = ab_q;
        busy_d  = busy_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;

        unique case (state_q)
            StIdle: begin
                // Results from the last sweep stay visible until a new start arrives.
                if (start) begin
                    ab_d    = '0;
                    err_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = SettleLoad;
                    state_d = StSettle;
                end
            end

            StSettle: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end

            StCheck: begin
                // s is looked at only here, so glitches during settling are ignored.
                if (mismatch) begin
                    err_d = err_q + (N + 1)'(1);
                    if (err_q == '0) begin
                        fail_d = ab_q;
                    end
                end
                if (last_row) begin
                    state_d = StDone;
                end else begin
                    ab_d    = ab_q + N'(1);
                    cnt_d   = SettleLoad;
                    state_d = StSettle;
                end
            end

            StDone: begin
                // A start in this cycle is dropped on purpose, so it does not queue another sweep.
                busy_d  = 1'b0;
                pass_d  = (err_q == '0);
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ab        = ab_q;
    assign busy      = busy_q;
    assign done      = (state_q == StDone);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_row  = fail_q;

endmodule

// File: tb/tb_f5_sweep.sv
// Directed bench for f5_sweep with two instances: N=2/SETTLE=1 and N=2/SETTLE=3.
// A small gate model drives s from ab (correct NOR, stuck-at faults, AND).
module tb_f5_sweep;

    logic       clk;
    logic       reset;
    logic       start1, start3;
    logic [1:0] ab1, ab3;
    logic       s1, s3;
    logic       busy1, busy3;
    logic       done1, done3;
    logic       pass1, pass3;
    logic [2:0] err1, err3;
    logic [1:0] fail1, fail3;

    int   mode;    // 0 NOR, 1 stuck-0, 2 stuck-1, 3 AND
    logic glitch;  // inverts s1 while high

    int checks;
    int errors;

    f5_sweep #(.N(2), .SETTLE(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start1),
        .ab        (ab1),
        .s         (s1),
        .busy      (busy1),
        .done      (done1),
        .pass      (pass1),
        .err_count (err1),
        .fail_row  (fail1)
    );

    f5_sweep #(.N(2), .SETTLE(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .start     (start3),
        .ab        (ab3),
        .s         (s3),
        .busy      (busy3),
        .done      (done3),
        .pass      (pass3),
        .err_count (err3),
        .fail_row  (fail3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic gate(input int m, input logic [1:0] v);
        case (m)
            0:       return ~v[1] & ~v[0];
            1:       return 1'b0;
            2:       return 1'b1;
            default: return v[1] & v[0];
        endcase
    endfunction

    assign s1 = gate(mode, ab1) ^ glitch;
    assign s3 = gate(mode, ab3);

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full sweep on the SETTLE=1 instance, optionally glitching s during settle cycles.
    task automatic sweep1(input int m, input bit gl, input logic [2:0] e_err,
                          input logic [1:0] e_row, input bit e_pass);
        mode   = m;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check(32'(busy1), 32'd1, "s1_busy_after_start");
        check(32'(pass1), 32'd0, "s1_pass_cleared");
        for (int r = 0; r < 4; r++) begin
            check(32'(ab1), 32'(r), "s1_ab_row");
            check(32'(done1), 32'd0, "s1_no_early_done");
            if (gl) glitch = 1'b1;
            tick();
            glitch = 1'b0;
            check(32'(ab1), 32'(r), "s1_ab_held");
            tick();
        end
        check(32'(done1), 32'd1, "s1_done_pulse");
        check(32'(busy1), 32'd1, "s1_busy_in_done");
        tick();
        check(32'(done1), 32'd0, "s1_done_one_cycle");
        check(32'(busy1), 32'd0, "s1_busy_fall");
        check(32'(pass1), 32'(e_pass), "s1_pass");
        check(32'(err1), 32'(e_err), "s1_err_count");
        if (e_err != 3'd0) check(32'(fail1), 32'(e_row), "s1_fail_row");
    endtask

    // One full sweep on the SETTLE=3 instance: four cycles per row.
    task automatic sweep3(input int m, input logic [2:0] e_err,
                          input logic [1:0] e_row, input bit e_pass);
        mode   = m;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int r = 0; r < 4; r++) begin
            check(32'(ab3), 32'(r), "s3_ab_row");
            tick();
            tick();
            tick();
            check(32'(ab3), 32'(r), "s3_ab_held");
            check(32'(done3), 32'd0, "s3_no_early_done");
            tick();
        end
        check(32'(done3), 32'd1, "s3_done_pulse");
        tick();
        check(32'(done3), 32'd0, "s3_done_one_cycle");
        check(32'(busy3), 32'd0, "s3_busy_fall");
        check(32'(pass3), 32'(e_pass), "s3_pass");
        check(32'(err3), 32'(e_err), "s3_err_count");
        if (e_err != 3'd0) check(32'(fail3), 32'(e_row), "s3_fail_row");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mode   = 0;
        glitch = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        reset  = 1'b1;

        tick();
        check(32'(ab1), 32'd0, "rst_ab");
        check(32'(busy1), 32'd0, "rst_busy");
        check(32'(done1), 32'd0, "rst_done");
        check(32'(pass1), 32'd0, "rst_pass");
        check(32'(err1), 32'd0, "rst_err");
        check(32'(fail1), 32'd0, "rst_fail_row");
        check(32'(busy3), 32'd0, "rst3_busy");
        reset = 1'b0;
        tick();

        // Correct gate, then the same gate with glitches outside CHECK.
        sweep1(0, 1'b0, 3'd0, 2'b00, 1'b1);
        tick();
        check(32'(pass1), 32'd1, "s1_pass_held_idle");
        sweep1(0, 1'b1, 3'd0, 2'b00, 1'b1);

        // Stuck-at and wrong-gate faults.
        sweep1(1, 1'b0, 3'd1, 2'b00, 1'b0);
        tick();
        check(32'(err1), 32'd1, "s1_err_held_idle");
        sweep1(2, 1'b0, 3'd3, 2'b01, 1'b0);
        sweep1(3, 1'b0, 3'd2, 2'b00, 1'b0);

        // Start held high; reset asynchronously while row 10 is driven.
        mode   = 2;
        start1 = 1'b1;
        tick();
        tick();
        tick();
        check(32'(ab1), 32'd1, "hold_ab_row1");
        tick();
        tick();
        check(32'(ab1), 32'd2, "hold_ab_row2");
        check(32'(err1), 32'd1, "hold_err_before_rst");
        check(32'(fail1), 32'd1, "hold_fail_before_rst");
        #3;
        reset = 1'b1;
        #1;
        check(32'(ab1), 32'd0, "async_rst_ab");
        check(32'(busy1), 32'd0, "async_rst_busy");
        check(32'(err1), 32'd0, "async_rst_err");
        check(32'(fail1), 32'd0, "async_rst_fail_row");
        check(32'(done1), 32'd0, "async_rst_done");
        start1 = 1'b0;
        #2;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check(32'(done1), 32'd0, "post_rst_no_done");
            check(32'(busy1), 32'd0, "post_rst_idle");
        end

        // A fresh sweep after reset starts again from row 00.
        sweep1(0, 1'b0, 3'd0, 2'b00, 1'b1);

        // Longer settle interval.
        sweep3(0, 3'd0, 2'b00, 1'b1);
        sweep3(2, 3'd3, 2'b01, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/f5_sweep.md
# f5_sweep

Sequential truth-table sweeper placed directly upstream of the two-input NOR stage (s = ~a & ~b). On a start request it drives every input combination onto the gate, waits a settle interval, samples the gate output and compares it against the expected NOR value. It counts mismatches and records the first failing row, so the gate is checked in-circuit without a hand-written stimulus list. Width is parameterised, so the same block also exercises N-input NOR variants.

## Interface
- N, default 2: number of gate inputs driven; must be ≥ 1.
- SETTLE, default 1: wait cycles between driving a row and sampling s; must be ≥ 1.

- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset. Single clock domain.
- start  input  1  sweep request; sampled only in IDLE.
- ab  output  N  stimulus to the gate; ab[N-1] is a, ab[0] is the last input (b for N=2).
- s  input  1  gate output under check.
- busy  output  1  high from the cycle after start is accepted until the sweep ends.
- done  output  1  one-cycle pulse when the sweep ends.
- pass  output  1  high when the last completed sweep had zero mismatches.
- err_count  output  N+1  number of mismatching rows in the current or last sweep.
- fail_row  output  N  ab value of the first mismatching row; valid only when err_count ≠ 0.

## Operation
- Expected value for row r: exp = 1 when r == 0, else exp = 0. This is NOR of all N bits.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE: when start = 1, the block sets ab ← 0, err_count ← 0, fail_row ← 0, pass ← 0, busy ← 1 and the wait counter ← SETTLE, then moves to SETTLE.
- SETTLE: the wait counter decrements each cycle. When it reaches 1, the next state is CHECK. ab is held.
- CHECK (one cycle): the block samples s.
  - If s ≠ exp, err_count increments; if err_count was 0, fail_row ← ab.
  - If ab is all ones, the next state is DONE.
  - Otherwise ab ← ab + 1, the wait counter reloads to SETTLE, and the next state is SETTLE.
- DONE (one cycle): done = 1, busy ← 0, pass ← (err_count == 0), then IDLE.
- start is ignored in SETTLE, CHECK and DONE. A start in the same cycle as DONE is not queued.
- ab counts 0 → 2^N−1 and never wraps within a sweep. err_count can reach 2^N at most, so it cannot overflow.
- err_count, fail_row, pass and ab hold their values in IDLE until the next accepted start.

## Timing
- Reset values: state IDLE, ab = 0, busy = 0, done = 0, pass = 0, err_count = 0, fail_row = 0.
- Reset asserted mid-sweep forces all reset values immediately, with no clock needed. No done pulse is produced.
- Start accepted at edge k:
  - Row 0 is driven from edge k.
  - Each row occupies SETTLE + 1 cycles.
  - Row r is sampled at edge k + (r+1)(SETTLE+1).
  - done is high for the single cycle following edge k + 2^N(SETTLE+1).
  - busy falls at the same edge that ends the done cycle.
- For N=2, SETTLE=1: samples at k+2, k+4, k+6, k+8; done is high during cycle k+8..k+9.
- s is sampled only at the CHECK edge. Glitches on s at any other time have no effect.

## Test plan
- Correct NOR gate, N=2, SETTLE=1, start pulsed at cycle 0 → ab steps 00, 01, 10, 11 every 2 cycles; done pulse after edge 8; err_count = 0, pass = 1.
- s stuck at 0 → err_count = 1, fail_row = 00, pass = 0.
- s stuck at 1 → err_count = 3, fail_row = 01, pass = 0.
- AND gate substituted (s = a & b) → rows 00 and 11 mismatch; err_count = 2, fail_row = 00, pass = 0.
- Start held high through the whole sweep, then reset pulsed while ab = 10 → exactly one sweep runs before the reset; on reset, all outputs return to reset values asynchronously and no done pulse occurs. A new start then sweeps again from ab = 00.
- SETTLE=3 with a correct gate → each row lasts 4 cycles; done pulse after edge 16; pass = 1.
